// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore-style sequencer for a multi-cycle MIPS datapath. It steps the
//   shared ALU, the unified instruction/data memory port, the register file
//   and the PC through the fetch, decode, execute, memory and writeback
//   states. Supported instructions are R-type, ori, lw, sw, beq and j. Every
//   memory state waits on the mem_ready_i handshake. The block also counts
//   retired instructions and traps on illegal opcodes.
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-low reset
//   start_i       leave IDLE (sampled only in IDLE)
//   opcode_i      IR[31:26], valid from DECODE onward
//   zero_i        ALU zero flag (only used by BRANCH)
//   mem_ready_i   memory completes the current access this cycle
//   pc_write_o, ir_write_o, mem_read_o, mem_write_o, iord_o
//   reg_write_o, reg_dst_o, mem_to_reg_o
//   alu_src_a_o   0 = PC, 1 = reg A
//   alu_src_b_o   00 = reg B, 01 = 4, 10 = ext imm, 11 = sext imm << 2
//   ext_zero_o    1 = zero-extend imm
//   alu_op_o      00 = add, 01 = sub, 10 = funct, 11 = or
//   pc_src_o      00 = ALU result, 01 = ALUOut, 10 = jump target
//   state_o       current state encoding
//   instr_done_o  final cycle of an instruction (retire)
//   illegal_o     controller is in TRAP
//   instr_cnt_o   retired-instruction count, wraps
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE  0  | waiting for start_i after reset
// FETCH 1  | read instruction at PC, PC += 4 when memory is ready
// DECODE 2 | precompute branch target, dispatch on opcode
// MADDR 3  | lw/sw address = A + sext(imm)
// MRD   4  | lw data read, waits for mem_ready_i
// MWB   5  | lw writeback to rt, retire
// MWR   6  | sw data write, waits for mem_ready_i, retire
// REXEC 7  | R-type ALU operation on funct
// RWB   8  | R-type writeback to rd, retire
// OEXEC 9  | ori: A | zext(imm)
// OWB   10 | ori writeback to rt, retire
// BRANCH 11| beq compare, load PC from ALUOut on zero, retire
// JUMP  12 | load jump target, retire
// TRAP  13 | illegal opcode, absorbing until reset
// 14, 15   | unused, recover into TRAP

module multicycle_control #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [5:0]           opcode_i,
  input  logic                 zero_i,
  input  logic                 mem_ready_i,
  output logic                 pc_write_o,
  output logic                 ir_write_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic                 iord_o,
  output logic                 reg_write_o,
  output logic                 reg_dst_o,
  output logic                 mem_to_reg_o,
  output logic                 alu_src_a_o,
  output logic [1:0]           alu_src_b_o,
  output logic                 ext_zero_o,
  output logic [1:0]           alu_op_o,
  output logic [1:0]           pc_src_o,
  output logic [3:0]           state_o,
  output logic                 instr_done_o,
  output logic                 illegal_o,
  output logic [CNT_WIDTH-1:0] instr_cnt_o
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_R_EXEC   = 4'd7;
  localparam logic [3:0] S_R_WB     = 4'd8;
  localparam logic [3:0] S_ORI_EXEC = 4'd9;
  localparam logic [3:0] S_ORI_WB   = 4'd10;
  localparam logic [3:0] S_BRANCH   = 4'd11;
  localparam logic [3:0] S_JUMP     = 4'd12;
  localparam logic [3:0] S_TRAP     = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [3:0] state;
  logic [3:0] state_nxt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Wraps naturally at all-ones.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instr_cnt_o <= '0;
    end else if (instr_done_o) begin
      instr_cnt_o <= instr_cnt_o + CNT_ONE;
    end
  end

  assign state_o = state;

  always_comb begin
    state_nxt    = state;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    iord_o       = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    ext_zero_o   = 1'b0;
    alu_op_o     = 2'b00;
    pc_src_o     = 2'b00;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start_i) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        // IR and PC only load on the cycle the memory actually delivers.
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_nxt  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b_o = 2'b11;
        case (opcode_i)
          OP_RTYPE:     state_nxt = S_R_EXEC;
          OP_ORI:       state_nxt = S_ORI_EXEC;
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_nxt   = (opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        instr_done_o = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        if (mem_ready_i) begin
          instr_done_o = 1'b1;
          state_nxt    = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b00;
        alu_op_o    = 2'b10;
        state_nxt   = S_R_WB;
      end
      S_R_WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = 1'b1;
        instr_done_o = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_ORI_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        ext_zero_o  = 1'b1;
        alu_op_o    = 2'b11;
        state_nxt   = S_ORI_WB;
      end
      S_ORI_WB: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b01;
        pc_src_o     = 2'b01;
        pc_write_o   = zero_i;
        instr_done_o = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_JUMP: begin
        pc_write_o   = 1'b1;
        pc_src_o     = 2'b10;
        instr_done_o = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_TRAP: begin
        illegal_o = 1'b1;
        state_nxt = S_TRAP;
      end
      default: begin
        state_nxt = S_TRAP;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

  typedef struct {
    logic       start;
    logic       rdy;
    logic       zero;
    logic [5:0] opc;
    logic [3:0] st;
    ctl_t       c;
    logic [3:0] cnt;
  } cyc_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [5:0] opcode_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       pc_write_o, ir_write_o, mem_read_o, mem_write_o, iord_o;
  logic       reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, alu_op_o, pc_src_o;
  logic       ext_zero_o, instr_done_o, illegal_o;
  logic [3:0] state_o;
  logic [3:0] instr_cnt_o;

  ctl_t obs;
  assign obs = {pc_write_o, ir_write_o, mem_read_o, mem_write_o, iord_o,
                reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
                ext_zero_o, alu_op_o, pc_src_o, instr_done_o, illegal_o};

  int checks = 0;
  int errors = 0;
  cyc_t sb[$];
  logic [3:0] exp_cnt = 4'd0;

  multicycle_control #(.CNT_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .opcode_i(opcode_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .ir_write_o(ir_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .iord_o(iord_o), .reg_write_o(reg_write_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .ext_zero_o(ext_zero_o), .alu_op_o(alu_op_o),
    .pc_src_o(pc_src_o), .state_o(state_o), .instr_done_o(instr_done_o),
    .illegal_o(illegal_o), .instr_cnt_o(instr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected control word for each state, written from the state descriptions.
  function automatic ctl_t c_none();
    ctl_t c; c = '0; return c;
  endfunction
  function automatic ctl_t c_fetch(input logic rdy);
    ctl_t c; c = '0; c.mem_read = 1; c.alu_src_b = 2'b01;
    c.ir_write = rdy; c.pc_write = rdy; return c;
  endfunction
  function automatic ctl_t c_decode();
    ctl_t c; c = '0; c.alu_src_b = 2'b11; return c;
  endfunction
  function automatic ctl_t c_addr();
    ctl_t c; c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10; return c;
  endfunction
  function automatic ctl_t c_memrd();
    ctl_t c; c = '0; c.mem_read = 1; c.iord = 1; return c;
  endfunction
  function automatic ctl_t c_memwb();
    ctl_t c; c = '0; c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; return c;
  endfunction
  function automatic ctl_t c_memwr(input logic rdy);
    ctl_t c; c = '0; c.mem_write = 1; c.iord = 1; c.instr_done = rdy; return c;
  endfunction
  function automatic ctl_t c_rexec();
    ctl_t c; c = '0; c.alu_src_a = 1; c.alu_op = 2'b10; return c;
  endfunction
  function automatic ctl_t c_rwb();
    ctl_t c; c = '0; c.reg_write = 1; c.reg_dst = 1; c.instr_done = 1; return c;
  endfunction
  function automatic ctl_t c_oexec();
    ctl_t c; c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10; c.ext_zero = 1;
    c.alu_op = 2'b11; return c;
  endfunction
  function automatic ctl_t c_owb();
    ctl_t c; c = '0; c.reg_write = 1; c.instr_done = 1; return c;
  endfunction
  function automatic ctl_t c_branch(input logic z);
    ctl_t c; c = '0; c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01;
    c.pc_write = z; c.instr_done = 1; return c;
  endfunction
  function automatic ctl_t c_jump();
    ctl_t c; c = '0; c.pc_write = 1; c.pc_src = 2'b10; c.instr_done = 1; return c;
  endfunction
  function automatic ctl_t c_trap();
    ctl_t c; c = '0; c.illegal = 1; return c;
  endfunction

  // Queue one cycle of stimulus with its expected response; the count model
  // advances after any cycle that is expected to retire.
  task automatic push(input logic start, input logic rdy, input logic zero,
                      input logic [5:0] opc, input logic [3:0] st, input ctl_t c);
    cyc_t e;
    e.start = start; e.rdy = rdy; e.zero = zero; e.opc = opc;
    e.st = st; e.c = c; e.cnt = exp_cnt;
    sb.push_back(e);
    if (c.instr_done) exp_cnt = exp_cnt + 4'd1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push_fetch(input logic [5:0] opc, input int waits);
    for (int i = 0; i < waits; i++) push(rbit(), 0, rbit(), opc, 4'd1, c_fetch(0));
    push(rbit(), 1, rbit(), opc, 4'd1, c_fetch(1));
    push(rbit(), rbit(), rbit(), opc, 4'd2, c_decode());
  endtask

  task automatic push_r();
    push_fetch(OP_R, 0);
    push(0, rbit(), rbit(), OP_R, 4'd7, c_rexec());
    push(0, rbit(), rbit(), OP_R, 4'd8, c_rwb());
  endtask

  task automatic push_ori();
    push_fetch(OP_ORI, 0);
    push(0, rbit(), rbit(), OP_ORI, 4'd9, c_oexec());
    push(0, rbit(), rbit(), OP_ORI, 4'd10, c_owb());
  endtask

  task automatic push_lw(input int waits);
    push_fetch(OP_LW, 0);
    push(0, rbit(), rbit(), OP_LW, 4'd3, c_addr());
    for (int i = 0; i < waits; i++) push(0, 0, rbit(), OP_LW, 4'd4, c_memrd());
    push(0, 1, rbit(), OP_LW, 4'd4, c_memrd());
    push(0, rbit(), rbit(), OP_LW, 4'd5, c_memwb());
  endtask

  task automatic push_sw(input int waits, input logic finish);
    push_fetch(OP_SW, 0);
    push(0, rbit(), rbit(), OP_SW, 4'd3, c_addr());
    for (int i = 0; i < waits; i++) push(0, 0, rbit(), OP_SW, 4'd6, c_memwr(0));
    if (finish) push(0, 1, rbit(), OP_SW, 4'd6, c_memwr(1));
  endtask

  task automatic push_beq(input logic z);
    push_fetch(OP_BEQ, 0);
    push(0, rbit(), z, OP_BEQ, 4'd11, c_branch(z));
  endtask

  task automatic push_j();
    push_fetch(OP_J, 0);
    push(0, rbit(), rbit(), OP_J, 4'd12, c_jump());
  endtask

  task automatic push_idle_wait();
    push(0, 0, 0, OP_R, 4'd1, c_fetch(0));
  endtask

  task automatic test_reset();
    rst_i = 0; start_i = 1; mem_ready_i = 1; zero_i = 1; opcode_i = OP_J;
    repeat (2) @(negedge clk_i);
    #1;
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
    checks++; if (obs !== c_none()) begin errors++; $display("FAIL reset_ctl got %h want 0", obs); end
    checks++; if (instr_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", instr_cnt_o); end
    @(negedge clk_i);
    start_i = 0; rst_i = 1;
    exp_cnt = 4'd0;
  endtask

  task automatic test_rtype();
    cyc_t e;
    push(0, 1, 1, OP_R, 4'd0, c_none());
    push(0, 0, 0, OP_R, 4'd0, c_none());
    push(1, 1, 0, OP_R, 4'd0, c_none());
    push_r();
    push_idle_wait();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk_i);
      start_i = e.start; mem_ready_i = e.rdy; zero_i = e.zero; opcode_i = e.opc;
      #1;
      checks++; if (state_o !== e.st) begin errors++; $display("FAIL rtype_state got %0d want %0d", state_o, e.st); end
      checks++; if (obs !== e.c) begin errors++; $display("FAIL rtype_ctl st %0d got %h want %h", e.st, obs, e.c); end
      checks++; if (instr_cnt_o !== e.cnt) begin errors++; $display("FAIL rtype_cnt got %0d want %0d", instr_cnt_o, e.cnt); end
    end
  endtask

  task automatic test_lw_wait();
    cyc_t e;
    push_lw(2);
    push_idle_wait();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk_i);
      start_i = e.start; mem_ready_i = e.rdy; zero_i = e.zero; opcode_i = e.opc;
      #1;
      checks++; if (state_o !== e.st) begin errors++; $display("FAIL lw_state got %0d want %0d", state_o, e.st); end
      checks++; if (obs !== e.c) begin errors++; $display("FAIL lw_ctl st %0d got %h want %h", e.st, obs, e.c); end
      checks++; if (instr_cnt_o !== e.cnt) begin errors++; $display("FAIL lw_cnt got %0d want %0d", instr_cnt_o, e.cnt); end
    end
  endtask

  task automatic test_ori_beq();
    cyc_t e;
    push_ori();
    push_beq(1);
    push_beq(0);
    push_idle_wait();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk_i);
      start_i = e.start; mem_ready_i = e.rdy; zero_i = e.zero; opcode_i = e.opc;
      #1;
      checks++; if (state_o !== e.st) begin errors++; $display("FAIL beq_state got %0d want %0d", state_o, e.st); end
      checks++; if (obs !== e.c) begin errors++; $display("FAIL beq_ctl st %0d got %h want %h", e.st, obs, e.c); end
      checks++; if (instr_cnt_o !== e.cnt) begin errors++; $display("FAIL beq_cnt got %0d want %0d", instr_cnt_o, e.cnt); end
    end
  endtask

  task automatic test_sw_j();
    cyc_t e;
    push_sw(0, 1);
    push_j();
    push_sw(1, 1);
    push_idle_wait();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk_i);
      start_i = e.start; mem_ready_i = e.rdy; zero_i = e.zero; opcode_i = e.opc;
      #1;
      checks++; if (state_o !== e.st) begin errors++; $display("FAIL swj_state got %0d want %0d", state_o, e.st); end
      checks++; if (obs !== e.c) begin errors++; $display("FAIL swj_ctl st %0d got %h want %h", e.st, obs, e.c); end
      checks++; if (instr_cnt_o !== e.cnt) begin errors++; $display("FAIL swj_cnt got %0d want %0d", instr_cnt_o, e.cnt); end
    end
  endtask

  task automatic test_trap();
    cyc_t e;
    push_fetch(OP_BAD, 0);
    for (int i = 0; i < 20; i++) push(rbit(), rbit(), rbit(), OP_BAD, 4'd13, c_trap());
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk_i);
      start_i = e.start; mem_ready_i = e.rdy; zero_i = e.zero; opcode_i = e.opc;
      #1;
      checks++; if (state_o !== e.st) begin errors++; $display("FAIL trap_state got %0d want %0d", state_o, e.st); end
      checks++; if (obs !== e.c) begin errors++; $display("FAIL trap_ctl st %0d got %h want %h", e.st, obs, e.c); end
      checks++; if (instr_cnt_o !== e.cnt) begin errors++; $display("FAIL trap_cnt got %0d want %0d", instr_cnt_o, e.cnt); end
    end
    @(negedge clk_i);
    start_i = 0; rst_i = 0;
    #1;
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL trap_rst_state got %0d want 0", state_o); end
    checks++; if (obs !== c_none()) begin errors++; $display("FAIL trap_rst_ctl got %h want 0", obs); end
    checks++; if (instr_cnt_o !== 4'd0) begin errors++; $display("FAIL trap_rst_cnt got %0d want 0", instr_cnt_o); end
    @(negedge clk_i);
    rst_i = 1;
    exp_cnt = 4'd0;
  endtask

  task automatic test_reset_mid_wait();
    cyc_t e;
    push(1, 0, 0, OP_SW, 4'd0, c_none());
    push_sw(2, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk_i);
      start_i = e.start; mem_ready_i = e.rdy; zero_i = e.zero; opcode_i = e.opc;
      #1;
      checks++; if (state_o !== e.st) begin errors++; $display("FAIL midrst_state got %0d want %0d", state_o, e.st); end
      checks++; if (obs !== e.c) begin errors++; $display("FAIL midrst_ctl st %0d got %h want %h", e.st, obs, e.c); end
      checks++; if (instr_cnt_o !== e.cnt) begin errors++; $display("FAIL midrst_cnt got %0d want %0d", instr_cnt_o, e.cnt); end
    end
    @(negedge clk_i);
    mem_ready_i = 0;
    #2;
    checks++; if (mem_write_o !== 1'b1) begin errors++; $display("FAIL midrst_wait_mw got %b want 1", mem_write_o); end
    rst_i = 0;
    #1;
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL midrst_abort_state got %0d want 0", state_o); end
    checks++; if (obs !== c_none()) begin errors++; $display("FAIL midrst_abort_ctl got %h want 0", obs); end
    mem_ready_i = 1;
    @(negedge clk_i);
    #1;
    checks++; if (mem_write_o !== 1'b0) begin errors++; $display("FAIL midrst_hold_mw got %b want 0", mem_write_o); end
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL midrst_hold_state got %0d want 0", state_o); end
    rst_i = 1;
    exp_cnt = 4'd0;
  endtask

  task automatic test_wrap();
    cyc_t e;
    push(1, 1, 0, OP_J, 4'd0, c_none());
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0: push_j();
        1: push_beq(rbit());
        2: push_ori();
        default: push_r();
      endcase
    end
    push_idle_wait();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk_i);
      start_i = e.start; mem_ready_i = e.rdy; zero_i = e.zero; opcode_i = e.opc;
      #1;
      checks++; if (state_o !== e.st) begin errors++; $display("FAIL wrap_state got %0d want %0d", state_o, e.st); end
      checks++; if (obs !== e.c) begin errors++; $display("FAIL wrap_ctl st %0d got %h want %h", e.st, obs, e.c); end
      checks++; if (instr_cnt_o !== e.cnt) begin errors++; $display("FAIL wrap_cnt got %0d want %0d", instr_cnt_o, e.cnt); end
    end
    checks++; if (instr_cnt_o !== 4'd0) begin errors++; $display("FAIL wrap_final_cnt got %0d want 0", instr_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_ori_beq();
    test_sw_j();
    test_trap();
    test_reset_mid_wait();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
